fibo_datapath: RTL

Datapath counterpart of the Fibonacci controller FSM. It consumes the controller's control word (write address/enable, clock enable, load select, two read addresses, ALU opcode, DONE) and returns ZERO_FLAG to the controller. It contains a small register file, a combinational ALU, a status-flag register and a result capture register. It sits between the controller and the top-level I/O (N input, Fibonacci result output).

---
 rtl/fibo_pkg.sv | 19 +
 rtl/fibo_alu.sv | 54 +++++
 rtl/fibo_datapath.sv | 90 +++++++++
 3 files changed

// File: rtl/fibo_pkg.sv
// Shared constants for the Fibonacci datapath: default sizing, derived widths and ALU opcodes.
package fibo_pkg;

    localparam int unsigned SIZE_DEF   = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W     = SIZE_DEF - 2;
    localparam int unsigned OPC_W      = SIZE_DEF - 1;
    localparam int unsigned NREGS      = 1 << ADDR_W;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

endpackage

// File: rtl/fibo_alu.sv
// Combinational ALU for the Fibonacci datapath. FIBO_DP_SAT_EN selects saturating
// arithmetic instead of modulo wrap-around; ovf reports carry/borrow either way.
module fibo_alu
    import fibo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OPC_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam logic [DATA_W:0] ONE = (DATA_W + 1)'(1);

    logic [DATA_W:0]   ext_a, ext_b, sum_ab, diff_ab, inc_a, dec_a;
    logic [DATA_W-1:0] raw;

    // The extra top bit carries out the carry (add) or borrow (subtract).
    assign ext_a   = {1'b0, a};
    assign ext_b   = {1'b0, b};
    assign sum_ab  = ext_a + ext_b;
    assign diff_ab = ext_a - ext_b;
    assign inc_a   = ext_a + ONE;
    assign dec_a   = ext_a - ONE;

    always_comb begin
        raw = '0;
        ovf = 1'b0;
        case (opcode)
            OP_W'(OP_PASS): raw = a;
            OP_W'(OP_ADD):  begin raw = sum_ab[DATA_W-1:0];  ovf = sum_ab[DATA_W];  end
            OP_W'(OP_SUB):  begin raw = diff_ab[DATA_W-1:0]; ovf = diff_ab[DATA_W]; end
            OP_W'(OP_DEC):  begin raw = dec_a[DATA_W-1:0];   ovf = dec_a[DATA_W];   end
            OP_W'(OP_INC):  begin raw = inc_a[DATA_W-1:0];   ovf = inc_a[DATA_W];   end
            OP_W'(OP_AND):  raw = a & b;
            OP_W'(OP_OR):   raw = a | b;
            default:        raw = '0;
        endcase
    end

`ifdef FIBO_DP_SAT_EN
    logic up_op;

    // Carries clamp to all-ones, borrows clamp to zero.
    assign up_op  = (opcode == OP_W'(OP_ADD)) || (opcode == OP_W'(OP_INC));
    assign result = !ovf ? raw : (up_op ? '1 : '0);
`else
    assign result = raw;
`endif

endmodule

// File: rtl/fibo_datapath.sv
// Fibonacci datapath: register file, ALU, zero/overflow flags and result capture.
// Optional saturating arithmetic via FIBO_DP_SAT_EN (see fibo_alu).
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int unsigned SIZE   = SIZE_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLK_EN,
    input  logic              WRT_EN,
    input  logic [SIZE-3:0]   WRT_ADDR,
    input  logic              LOAD_DATA,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [SIZE-3:0]   RD_ADDR1,
    input  logic [SIZE-3:0]   RD_ADDR2,
    input  logic [SIZE-2:0]   ALU_OPCODE,
    input  logic              DONE,
    output logic              ZERO_FLAG,
    output logic              OVF,
    output logic [DATA_W-1:0] RESULT,
    output logic              RESULT_VALID
);

    localparam int REG_N = 1 << (SIZE - 2);

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [DATA_W-1:0] op_a, op_b, alu_result, wr_data;
    logic              alu_ovf, wr_fire, cap_fire;
    logic              zero_q, ovf_q, valid_q;
    logic [DATA_W-1:0] result_q;

    assign op_a     = regs_q[RD_ADDR1];
    assign op_b     = regs_q[RD_ADDR2];
    assign wr_data  = LOAD_DATA ? DATA_IN : alu_result;
    assign wr_fire  = CLK_EN && WRT_EN;
    assign cap_fire = CLK_EN && DONE;

    fibo_alu #(
        .DATA_W (DATA_W),
        .OP_W   (SIZE - 1)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .opcode (ALU_OPCODE),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[WRT_ADDR] <= wr_data;
        end
    end

    // A fresh operand load restarts overflow tracking; ALU writes accumulate it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (wr_fire) begin
            zero_q <= (wr_data == '0);
            ovf_q  <= LOAD_DATA ? 1'b0 : (ovf_q | alu_ovf);
        end
    end

    // The valid pulse drops on the very next edge, even if the controller gates CLK_EN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= cap_fire;
            if (cap_fire) begin
                result_q <= op_a;
            end
        end
    end

    assign ZERO_FLAG    = zero_q;
    assign OVF          = ovf_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;

endmodule
